// File: rtl/axis_variable_delay_pkg.sv
// Shared types and helpers for the programmable AXI4-Stream sample delay.
package axis_variable_delay_pkg;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Status word layout: fill count in the low bits, RUN flag just above it.
  localparam int STS_FILL_LSB = 0;

  function automatic int sts_run_bit(input int cntr_width);
    return cntr_width;
  endfunction

  function automatic int depth(input int cntr_width);
    return 1 << cntr_width;
  endfunction

endpackage

// File: rtl/axis_variable_delay_if.sv
// AXI4-Stream beat channel (data/valid/ready) with master and slave views.
interface axis_variable_delay_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_delay_ram.sv
// Simple dual-port sample buffer: synchronous write, asynchronous read (distributed RAM).
module axis_delay_ram
  import axis_variable_delay_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH_C = depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH_C];

  // Write port; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axis_variable_delay.sv
// Programmable-depth AXI4-Stream delay: output beat k carries x[k-D] (0 while priming).
// Optional status port sts_data enabled by defining AXIS_VARIABLE_DELAY_STATUS_EN.
module axis_variable_delay
  import axis_variable_delay_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  axis_variable_delay_if.slave  s_axis,
  axis_variable_delay_if.master m_axis
`ifdef AXIS_VARIABLE_DELAY_STATUS_EN
  ,
  output logic [CNTR_WIDTH:0]   sts_data
`endif
);

  localparam logic [CNTR_WIDTH-1:0]       PTR_ZERO_C  = {CNTR_WIDTH{1'b0}};
  localparam logic [CNTR_WIDTH-1:0]       PTR_ONE_C   = CNTR_WIDTH'(1);
  localparam logic [AXIS_TDATA_WIDTH-1:0] DATA_ZERO_C = {AXIS_TDATA_WIDTH{1'b0}};

  state_e                        state_r;
  state_e                        state_nx_s;
  logic [CNTR_WIDTH-1:0]         cfg_r;
  logic [CNTR_WIDTH-1:0]         wr_ptr_r;
  logic [CNTR_WIDTH-1:0]         fill_r;
  logic [CNTR_WIDTH-1:0]         fill_nx_s;
  logic [CNTR_WIDTH-1:0]         fill_inc_s;
  logic [CNTR_WIDTH-1:0]         rd_addr_s;
  logic [AXIS_TDATA_WIDTH-1:0]   rd_data_s;
  logic [AXIS_TDATA_WIDTH-1:0]   tdata_r;
  logic [AXIS_TDATA_WIDTH-1:0]   tdata_nx_s;
  logic                          tvalid_r;
  logic                          s_tready_s;
  logic                          accept_s;
  logic                          cfg_change_s;
  logic                          run_s;

  assign s_tready_s   = !tvalid_r || m_axis.tready;
  assign accept_s     = s_axis.tvalid && s_tready_s;
  assign cfg_change_s = (cfg_data != cfg_r);
  assign fill_inc_s   = fill_r + PTR_ONE_C;
  // The registered delay is used everywhere, so an accept during a cfg change sees the old D.
  assign rd_addr_s    = wr_ptr_r - cfg_r;
  // fill == D in PRIME only happens for D = 0, which must behave as RUN at once.
  assign run_s        = (state_r == ST_RUN) || (fill_r == cfg_r);

  assign s_axis.tready = s_tready_s;
  assign m_axis.tdata  = tdata_r;
  assign m_axis.tvalid = tvalid_r;

  axis_delay_ram #(
    .DATA_WIDTH (AXIS_TDATA_WIDTH),
    .ADDR_WIDTH (CNTR_WIDTH)
  ) u_ram (
    .clk   (aclk),
    .we    (accept_s),
    .waddr (wr_ptr_r),
    .wdata (s_axis.tdata),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Next-state and fill-counter logic for the PRIME/RUN machine.
  always_comb begin
    state_nx_s = state_r;
    fill_nx_s  = fill_r;
    if (cfg_change_s) begin
      state_nx_s = ST_PRIME;
      fill_nx_s  = PTR_ZERO_C;
    end else begin
      case (state_r)
        ST_PRIME: begin
          if (fill_r == cfg_r) begin
            state_nx_s = ST_RUN;
          end else if (accept_s) begin
            fill_nx_s = fill_inc_s;
            if (fill_inc_s == cfg_r) begin
              state_nx_s = ST_RUN;
            end else begin
              state_nx_s = ST_PRIME;
            end
          end else begin
            state_nx_s = ST_PRIME;
          end
        end
        ST_RUN: begin
          state_nx_s = ST_RUN;
        end
        default: begin
          state_nx_s = ST_PRIME;
          fill_nx_s  = PTR_ZERO_C;
        end
      endcase
    end
  end

  // Output-register data selection: zero while priming, bypass for D = 0, else the tap.
  always_comb begin
    tdata_nx_s = DATA_ZERO_C;
    if (!run_s) begin
      tdata_nx_s = DATA_ZERO_C;
    end else if (cfg_r == PTR_ZERO_C) begin
      tdata_nx_s = s_axis.tdata;
    end else begin
      tdata_nx_s = rd_data_s;
    end
  end

  // State, fill, registered cfg copy and write pointer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r  <= ST_PRIME;
      fill_r   <= PTR_ZERO_C;
      cfg_r    <= PTR_ZERO_C;
      wr_ptr_r <= PTR_ZERO_C;
    end else begin
      state_r <= state_nx_s;
      fill_r  <= fill_nx_s;
      cfg_r   <= cfg_data;
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
    end
  end

  // One-deep output register; holds steady while the consumer stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_r  <= DATA_ZERO_C;
      tvalid_r <= 1'b0;
    end else if (accept_s) begin
      tdata_r  <= tdata_nx_s;
      tvalid_r <= 1'b1;
    end else if (m_axis.tready) begin
      tvalid_r <= 1'b0;
    end
  end

`ifdef AXIS_VARIABLE_DELAY_STATUS_EN
  localparam int RUN_BIT_C = sts_run_bit(CNTR_WIDTH);

  logic [CNTR_WIDTH:0] sts_r;

  // Status mirrors the state/fill registers so it reads {RUN, fill} of the current cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sts_r <= {(CNTR_WIDTH + 1){1'b0}};
    end else begin
      sts_r[RUN_BIT_C] <= (state_nx_s == ST_RUN);
      sts_r[STS_FILL_LSB +: CNTR_WIDTH] <= fill_nx_s;
    end
  end

  assign sts_data = sts_r;
`endif

endmodule

// File: tb/tb_axis_variable_delay.sv
// Directed self-checking bench for axis_variable_delay (default build, CNTR_WIDTH = 5).
module tb_axis_variable_delay;

  logic       aclk;
  logic       aresetn;
  logic [4:0] cfg_data;
  int         checks;
  int         failures;

  axis_variable_delay_if #(.DATA_WIDTH(32)) s_if ();
  axis_variable_delay_if #(.DATA_WIDTH(32)) m_if ();

  axis_variable_delay #(
    .AXIS_TDATA_WIDTH (32),
    .CNTR_WIDTH       (5)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cfg_data (cfg_data),
    .s_axis   (s_if.slave),
    .m_axis   (m_if.master)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat, then check the registered output one cycle later.
  task automatic send(input logic [31:0] d, input logic [31:0] exp);
    @(negedge aclk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    @(posedge aclk);
    #1;
    chk("out_tvalid", {31'd0, m_if.tvalid}, 32'd1);
    chk("out_tdata", m_if.tdata, exp);
  endtask

  task automatic idle(input int n);
    @(negedge aclk);
    s_if.tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
    chk("idle_tvalid", {31'd0, m_if.tvalid}, 32'd0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    aresetn     = 1'b0;
    cfg_data    = 5'd3;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 32'd0;
    m_if.tready = 1'b1;
    #1;
    chk("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("rst_tdata", m_if.tdata, 32'd0);
    chk("rst_s_tready", {31'd0, s_if.tready}, 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    idle(2);

    // D = 3: three zero beats, then the stream shifted by three.
    send(32'd1, 32'd0);
    send(32'd2, 32'd0);
    send(32'd3, 32'd0);
    send(32'd4, 32'd1);
    send(32'd5, 32'd2);
    send(32'd6, 32'd3);

    // D = 0 bypass at full rate.
    cfg_data = 5'd0;
    idle(2);
    send(32'hA5, 32'hA5);
    send(32'h5A, 32'h5A);
    send(32'h1234_5678, 32'h1234_5678);

    // D = 31 exercises pointer wrap-around.
    cfg_data = 5'd31;
    idle(2);
    for (int k = 0; k < 100; k++) begin
      send(32'(k), (k >= 31) ? 32'(k - 31) : 32'd0);
    end

    // D = 2 with a 5-cycle consumer stall mid-stream.
    cfg_data = 5'd2;
    idle(2);
    send(32'd10, 32'd0);
    send(32'd11, 32'd0);
    send(32'd12, 32'd10);
    @(negedge aclk);
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'd13;
    #1;
    chk("stall_s_tready_now", {31'd0, s_if.tready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk);
      #1;
      chk("stall_s_tready", {31'd0, s_if.tready}, 32'd0);
      chk("stall_tvalid", {31'd0, m_if.tvalid}, 32'd1);
      chk("stall_tdata", m_if.tdata, 32'd10);
    end
    @(negedge aclk);
    m_if.tready = 1'b1;
    @(posedge aclk);
    #1;
    chk("release_tdata", m_if.tdata, 32'd11);
    send(32'd14, 32'd12);

    // Ten more D = 2 beats, then change D to 4.
    for (int i = 0; i < 10; i++) begin
      send(32'(20 + i), (i == 0) ? 32'd13 : (i == 1) ? 32'd14 : 32'(20 + i - 2));
    end
    cfg_data = 5'd4;
    idle(1);
    send(32'd30, 32'd0);
    send(32'd31, 32'd0);
    send(32'd32, 32'd0);
    send(32'd33, 32'd0);
    send(32'd34, 32'd30);
    send(32'd35, 32'd31);

    // Asynchronous reset mid-stream, then re-prime with D = 4.
    @(negedge aclk);
    s_if.tvalid = 1'b0;
    aresetn     = 1'b0;
    #1;
    chk("arst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
    chk("arst_tdata", m_if.tdata, 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    idle(2);
    send(32'd50, 32'd0);
    send(32'd51, 32'd0);
    send(32'd52, 32'd0);
    send(32'd53, 32'd0);
    send(32'd54, 32'd50);
    send(32'd55, 32'd51);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_variable_delay.md
# axis_variable_delay

Programmable-depth AXI4-Stream sample delay with full backpressure support. It is the read-side counterpart to our fixed shift-register delay. Samples are written into a circular buffer, and each output beat is read from a tap a run-time-selected number of accepted beats behind the write pointer. It sits between the ADC/DDS stream sources and downstream consumers (FIFOs, DMA writers) whose stream alignment must be trimmed from software through a cfg register.

## Interface
- AXIS_TDATA_WIDTH, 32, data width of both stream sides
- CNTR_WIDTH, 5, pointer width; buffer depth 2^CNTR_WIDTH, max delay 2^CNTR_WIDTH-1 beats
- aclk  input  1  clock; all logic on rising edge
- aresetn  input  1  reset; asynchronous, active-low
- cfg_data  input  CNTR_WIDTH  delay D in accepted beats; quasi-static, sampled every cycle
- s_axis_tready  output  1  slave ready
- s_axis_tdata  input  AXIS_TDATA_WIDTH  slave data
- s_axis_tvalid  input  1  slave valid
- m_axis_tready  input  1  master ready
- m_axis_tdata  output  AXIS_TDATA_WIDTH  delayed data, registered
- m_axis_tvalid  output  1  master valid, registered

## Operation
- Rate preserving: each accepted input beat k yields exactly one output beat carrying x[k-D]. If k < D, that output beat carries 0.
- Accept = s_axis_tvalid && s_axis_tready. On accept, the block writes s_axis_tdata to ram[wr_ptr] and increments wr_ptr modulo 2^CNTR_WIDTH.
- Read address = wr_ptr - D, modulo 2^CNTR_WIDTH, taken before the increment.
- D = 0 bypasses the RAM: the output register loads s_axis_tdata directly.
- States:
  - PRIME: fill counter below D. Output register loads 0 on accept. The fill counter increments on accept and saturates at D.
  - RUN: fill == D. Output register loads the RAM read data or the bypass value.
- Transitions:
  - PRIME -> RUN when an accept brings fill to D. This occurs in the same cycle as the accept, so the next accept is in RUN.
  - D = 0 enters RUN immediately.
  - Any change of cfg_data, detected against a registered copy, forces PRIME with fill = 0 on the next cycle. wr_ptr and RAM contents are kept. An accept in the change cycle uses the old D.
- Output register:
  - Loads on accept.
  - m_axis_tvalid is set on accept and cleared when m_axis_tready is high with no accept in the same cycle.
- Handshake: s_axis_tready = !m_axis_tvalid || m_axis_tready (one-deep output register, no combinational data path). Simultaneous drain and accept keeps tvalid high at full throughput.
- Wrap-around: pointer arithmetic wraps naturally. D ≤ 2^CNTR_WIDTH-1 guarantees the read slot is never the slot being written, except in the D=0 bypass.

## Timing
- Reset values: m_axis_tvalid = 0, m_axis_tdata = 0, wr_ptr = 0, fill = 0, state = PRIME, registered cfg = 0. RAM contents are not reset.
- Latency: 1 cycle from input accept to m_axis_tvalid/m_axis_tdata.
- Throughput: 1 beat/cycle when m_axis_tready is held high.
- Reset asserted mid-stream: outputs clear asynchronously and the pending output beat is lost. After release, the block re-primes from fill = 0.
- While m_axis_tvalid = 1 and m_axis_tready = 0, m_axis_tdata and m_axis_tvalid stay stable.

## Configuration
- AXIS_VARIABLE_DELAY_STATUS_EN defined:
  - Adds output sts_data [CNTR_WIDTH:0] = {state == RUN, fill}.
  - The output is registered, and its reset value is 0.
- Without the macro: the port is absent, and the datapath and state logic are identical.

## Structure
- Package axis_variable_delay_pkg holds:
  - state enum (PRIME, RUN)
  - DEPTH = 2**CNTR_WIDTH helper function
  - status field offsets
- Sub-module axis_delay_ram: simple dual-port RAM with one synchronous write port and one asynchronous read port, depth 2^CNTR_WIDTH, mapping to distributed RAM. Pointer, fill counter, FSM and output register stay in the top module.

## Test plan
- D=3, tready=1, input 1,2,3,4,5,6 on consecutive cycles -> outputs 0,0,0,1,2,3, each 1 cycle after its input beat.
- D=0, input 0xA5 -> m_axis_tdata = 0xA5 one cycle later, full rate, no zero beats.
- D=31 with CNTR_WIDTH=5, 100 incrementing beats -> beat k outputs k-31 for k≥31, 0 before. This exercises wrap-around.
- D=2 run, m_axis_tready held low 5 cycles mid-stream -> s_axis_tready drops after one beat is held, output data is stable, and no beat is lost or duplicated after release.
- D changed 2->4 after 10 beats -> the next 4 output beats are 0, then x[k-4].
- aresetn pulsed low mid-stream -> m_axis_tvalid = 0 immediately; after release, D zero beats precede the delayed data. With STATUS_EN, sts_data = 0 during reset and shows {1, D} once primed.
